// File: rtl/scope_pkg.sv
// Shared definitions for the sample word serializer and related lane streamers:
// FSM state encoding, counter widths and the lane byte count helper.
package scope_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        LOAD    = 3'd2,
        SEL     = 3'd3,
        WAIT_HI = 3'd4,
        WAIT_LO = 3'd5,
        NEXT    = 3'd6,
        TAIL    = 3'd7
    } state_t;

    // Counters are sized for the largest supported configuration (8 lanes, 32-bit lanes)
    // so the lane selector port widths stay fixed across parameterisations.
    localparam int MAX_CH     = 8;
    localparam int MAX_LANE_W = 32;
    localparam int LANE_CNT_W = $clog2(MAX_CH);
    localparam int BYTE_CNT_W = $clog2(MAX_LANE_W / 8);

    // Number of bytes carried by one lane (BYTES_PER_LANE for a given lane width).
    function automatic int bytes_per_lane(input int lane_w);
        return lane_w / 8;
    endfunction

endpackage

// File: rtl/scope_lane_byte_sel.sv
// Combinational lane/byte picker: selects one lane of a packed sample word,
// clears the bits above the sample width, and returns the requested byte.
module scope_lane_byte_sel
    import scope_pkg::*;
#(
    parameter int CH       = 2,
    parameter int LANE_W   = 16,
    parameter int SAMPLE_W = 14
) (
    input  logic [CH*LANE_W-1:0]  sample_buf,
    input  logic [LANE_CNT_W-1:0] lane,
    input  logic [BYTE_CNT_W-1:0] byte_idx,
    output logic [7:0]            byte_out
);

    logic [LANE_W-1:0] lane_bits;
    logic [LANE_W-1:0] lane_masked;

    // Slice the lane, zero the unused high bits, then pick byte k = bits [8k+7:8k].
    always_comb begin
        lane_bits = sample_buf[int'(lane)*LANE_W +: LANE_W];
        for (int i = 0; i < LANE_W; i++) begin
            lane_masked[i] = (i < SAMPLE_W) ? lane_bits[i] : 1'b0;
        end
        byte_out = lane_masked[int'(byte_idx)*8 +: 8];
    end

endmodule

// File: rtl/sample_word_serializer.sv
// Drains packed multi-lane ADC words from the sample FIFO and streams them byte by
// byte to the UART transmitter: lane 0 first, MSB byte first, disabled lanes skipped.
// Optional feature macro: CSUM_EN appends an XOR checksum byte after each sent word.
module sample_word_serializer
    import scope_pkg::*;
#(
    parameter int CH       = 2,
    parameter int LANE_W   = 16,
    parameter int SAMPLE_W = 14,
    parameter int WORD_W   = CH * LANE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [WORD_W-1:0] fifo_dout,
    input  logic [CH-1:0]     ch_mask,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              word_done
);

    localparam int BPL = bytes_per_lane(LANE_W);
    localparam logic [BYTE_CNT_W-1:0] BYTE_LAST = BYTE_CNT_W'(BPL - 1);

    state_t                state_q, state_d;
    logic [WORD_W-1:0]     buf_q, buf_d;
    logic [CH-1:0]         mask_q, mask_d;
    logic [LANE_CNT_W-1:0] lane_q, lane_d;
    logic [BYTE_CNT_W-1:0] byte_q, byte_d;
    logic                  hi_cnt_q, hi_cnt_d;
    logic                  rd_en_d, tx_start_d, word_done_d;
    logic [7:0]            tx_data_d;
    logic [LANE_CNT_W-1:0] sel_lane, next_lane;
    logic                  has_next;
    logic [7:0]            sel_byte;
`ifdef CSUM_EN
    logic [7:0]            csum_q, csum_d;
    logic                  tail_q, tail_d;
`endif

    // Lowest enabled lane at or above start (0 when none; callers check has_next first).
    function automatic logic [LANE_CNT_W-1:0] first_set_from(input logic [CH-1:0] m, input int start);
        logic [LANE_CNT_W-1:0] r;
        r = '0;
        for (int i = CH - 1; i >= 0; i--) begin
            if (i >= start && m[i]) r = LANE_CNT_W'(i);
        end
        return r;
    endfunction

    function automatic logic any_set_from(input logic [CH-1:0] m, input int start);
        logic r;
        r = 1'b0;
        for (int i = 0; i < CH; i++) begin
            if (i >= start && m[i]) r = 1'b1;
        end
        return r;
    endfunction

    // Disabled lanes are skipped combinationally, so they cost no cycles.
    always_comb begin
        sel_lane  = first_set_from(mask_q, int'(lane_q));
        next_lane = first_set_from(mask_q, int'(lane_q) + 1);
        has_next  = any_set_from(mask_q, int'(lane_q) + 1);
    end

    scope_lane_byte_sel #(
        .CH       (CH),
        .LANE_W   (LANE_W),
        .SAMPLE_W (SAMPLE_W)
    ) u_sel (
        .sample_buf (buf_q),
        .lane       (sel_lane),
        .byte_idx   (byte_q),
        .byte_out   (sel_byte)
    );

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        mask_d      = mask_q;
        lane_d      = lane_q;
        byte_d      = byte_q;
        hi_cnt_d    = hi_cnt_q;
        rd_en_d     = 1'b0;
        tx_start_d  = 1'b0;
        word_done_d = 1'b0;
        tx_data_d   = tx_data;
`ifdef CSUM_EN
        csum_d      = csum_q;
        tail_d      = tail_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    rd_en_d = 1'b1;
                    state_d = READ;
                end
            end
            READ: state_d = LOAD;
            LOAD: begin
                buf_d  = fifo_dout;
                mask_d = ch_mask;
                lane_d = '0;
                byte_d = BYTE_LAST;
`ifdef CSUM_EN
                csum_d = '0;
                tail_d = 1'b0;
`endif
                if (ch_mask == '0) begin
                    word_done_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    state_d = SEL;
                end
            end
            SEL: begin
                // A UART still busy from earlier traffic holds the byte back.
                if (!tx_busy) begin
                    lane_d     = sel_lane;
                    tx_data_d  = sel_byte;
                    tx_start_d = 1'b1;
                    hi_cnt_d   = 1'b0;
`ifdef CSUM_EN
                    csum_d     = csum_q ^ sel_byte;
`endif
                    state_d    = WAIT_HI;
                end
            end
            WAIT_HI: begin
                // A UART that never raises busy is treated as having sent the byte.
                if (tx_busy) begin
                    state_d = WAIT_LO;
                end else if (hi_cnt_q) begin
                    state_d = NEXT;
                end else begin
                    hi_cnt_d = 1'b1;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) state_d = NEXT;
            end
            NEXT: begin
`ifdef CSUM_EN
                if (tail_q) begin
                    word_done_d = 1'b1;
                    state_d     = IDLE;
                end else
`endif
                if (byte_q != '0) begin
                    byte_d  = byte_q - 1'b1;
                    state_d = SEL;
                end else begin
                    byte_d = BYTE_LAST;
                    if (has_next) begin
                        lane_d  = next_lane;
                        state_d = SEL;
                    end else begin
`ifdef CSUM_EN
                        state_d = TAIL;
`else
                        word_done_d = 1'b1;
                        state_d     = IDLE;
`endif
                    end
                end
            end
`ifdef CSUM_EN
            TAIL: begin
                if (!tx_busy) begin
                    tx_data_d  = csum_q;
                    tx_start_d = 1'b1;
                    tail_d     = 1'b1;
                    hi_cnt_d   = 1'b0;
                    state_d    = WAIT_HI;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Control state and registered outputs; reset aborts any word in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            lane_q     <= '0;
            byte_q     <= '0;
            hi_cnt_q   <= 1'b0;
            fifo_rd_en <= 1'b0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            word_done  <= 1'b0;
`ifdef CSUM_EN
            tail_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            lane_q     <= lane_d;
            byte_q     <= byte_d;
            hi_cnt_q   <= hi_cnt_d;
            fifo_rd_en <= rd_en_d;
            tx_start   <= tx_start_d;
            tx_data    <= tx_data_d;
            word_done  <= word_done_d;
`ifdef CSUM_EN
            tail_q     <= tail_d;
`endif
        end
    end

    // Word buffer and checksum are pure data; LOAD always rewrites them before use.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
`ifdef CSUM_EN
        csum_q <= csum_d;
`endif
    end

endmodule

// File: tb/tb_sample_word_serializer.sv
// Self-checking bench for sample_word_serializer: FIFO and UART models, a byte-list
// reference model per word, and directed scenarios with literal expectations.
module tb_sample_word_serializer;

    localparam int CH       = 2;
    localparam int LANE_W   = 16;
    localparam int SAMPLE_W = 14;
    localparam int WORD_W   = CH * LANE_W;
    localparam int BPL      = LANE_W / 8;
    localparam int BUSY_LEN = 3;
`ifdef CSUM_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [WORD_W-1:0] fifo_dout = '0;
    logic [CH-1:0]     ch_mask;
    logic              tx_busy = 1'b0;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              word_done;

    int pass_cnt = 0;
    int total_cnt = 0;

    // FIFO model: main writes mem/wr_ptr, FIFO process owns rd_ptr.
    logic [WORD_W-1:0] mem [64];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int rd_n = 0;
    assign fifo_empty = (rd_ptr == wr_ptr);

    // Expected byte stream: written by the FIFO process, consumed by the compare process.
    logic [7:0] exp_b [1024];
    int exp_wr = 0;
    int exp_rd = 0;

    // Observed byte log and event counts, owned by the compare process.
    logic [7:0] log_b [1024];
    int log_n = 0;
    int wd_n = 0;
    logic word_active = 1'b0;
    logic hold_valid = 1'b0;
    logic [7:0] last_tx = '0;

    // UART model controls.
    int ustart_n = 0;
    int ub_cnt = 0;
    int ign_lo = 0;
    int ign_hi = -1;

    sample_word_serializer #(
        .CH       (CH),
        .LANE_W   (LANE_W),
        .SAMPLE_W (SAMPLE_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .ch_mask    (ch_mask),
        .tx_busy    (tx_busy),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .word_done  (word_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: bytes a word must produce, from the arithmetic definition of lanes.
    function automatic void model_word(input logic [WORD_W-1:0] w, input logic [CH-1:0] m);
        longint lv;
        longint b;
        logic [7:0] x;
        x = 8'h00;
        for (int l = 0; l < CH; l++) begin
            if (m[l]) begin
                lv = (longint'(w) >> (l * LANE_W)) % (longint'(1) << LANE_W);
                lv = lv % (longint'(1) << SAMPLE_W);
                for (int k = BPL - 1; k >= 0; k--) begin
                    b = (lv >> (8 * k)) % 256;
                    exp_b[exp_wr % 1024] = 8'(b);
                    x = x ^ 8'(b);
                    exp_wr++;
                end
            end
        end
`ifdef CSUM_EN
        if (m != '0) begin
            exp_b[exp_wr % 1024] = x;
            exp_wr++;
        end
`endif
    endfunction

    // FIFO read port: data valid the cycle after fifo_rd_en.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_dout <= mem[rd_ptr % 64];
            model_word(mem[rd_ptr % 64], ch_mask);
            rd_ptr <= rd_ptr + 1;
            rd_n++;
        end
    end

    // UART model: busy for BUSY_LEN cycles after an accepted tx_start; selected pulses are ignored.
    always @(posedge clk) begin
        if (tx_start) begin
            ustart_n++;
            if (!(ustart_n >= ign_lo && ustart_n <= ign_hi)) ub_cnt = BUSY_LEN;
        end else if (ub_cnt > 0) begin
            ub_cnt--;
        end
        tx_busy <= (ub_cnt > 0);
    end

    // Compare process: checks every tx_start, word_done and read strobe against the model.
    always @(negedge clk) begin
        if (rst) begin
            exp_rd = exp_wr;
            word_active = 1'b0;
            hold_valid = 1'b0;
        end else begin
            if (fifo_rd_en) begin
                check("rd_en_before_word_done", longint'(word_active), 0);
                word_active = 1'b1;
            end
            if (hold_valid && tx_busy && !tx_start)
                check("tx_data_hold", longint'(tx_data), longint'(last_tx));
            if (tx_start) begin
                log_b[log_n % 1024] = tx_data;
                log_n++;
                last_tx = tx_data;
                hold_valid = 1'b1;
                if (exp_rd == exp_wr) begin
                    check("tx_start_unexpected", 1, 0);
                end else begin
                    check("tx_byte", longint'(tx_data), longint'(exp_b[exp_rd % 1024]));
                    exp_rd++;
                end
            end
            if (word_done) begin
                check("word_done_bytes_left", longint'(exp_wr - exp_rd), 0);
                word_active = 1'b0;
                wd_n++;
            end
        end
    end

    task automatic push(input logic [WORD_W-1:0] w);
        mem[wr_ptr % 64] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_wd(input int target, input int limit, input string name);
        int n;
        n = 0;
        while (wd_n < target && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (wd_n < target) check(name, longint'(wd_n), longint'(target));
    endtask

    task automatic wait_log(input int target, input int limit, input string name);
        int n;
        n = 0;
        while (log_n < target && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (log_n < target) check(name, longint'(log_n), longint'(target));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_fifo_rd_en"}, longint'(fifo_rd_en), 0);
        check({tag, "_tx_start"},   longint'(tx_start), 0);
        check({tag, "_tx_data"},    longint'(tx_data), 0);
        check({tag, "_word_done"},  longint'(word_done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base, wd0, rd0, lat, st0;
        rst = 1'b1;
        ch_mask = 2'b11;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Case 1: both lanes, first tx_start 4 cycles after the FIFO goes non-empty.
        base = log_n; wd0 = wd_n;
        push(32'hFF3C_C0A5);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (tx_start) begin lat = i; break; end
        end
        check("first_tx_latency", longint'(lat), 4);
        wait_wd(wd0 + 1, 200, "case1_word_done_timeout");
        check("case1_count", longint'(log_n - base), longint'(4 + EXTRA));
        check("case1_b0", longint'(log_b[base]),     8'h00);
        check("case1_b1", longint'(log_b[base + 1]), 8'hA5);
        check("case1_b2", longint'(log_b[base + 2]), 8'h3F);
        check("case1_b3", longint'(log_b[base + 3]), 8'h3C);
`ifdef CSUM_EN
        check("case6_csum", longint'(log_b[base + 4]), 8'hA6);
`endif
        repeat (2) @(negedge clk);

        // Case 2a: lane 0 disabled; a mask change mid-word must not matter.
        ch_mask = 2'b10;
        base = log_n; wd0 = wd_n;
        push(32'hFF3C_C0A5);
        wait_log(base + 1, 50, "case2a_first_byte_timeout");
        ch_mask = 2'b11;
        wait_wd(wd0 + 1, 200, "case2a_word_done_timeout");
        check("case2a_count", longint'(log_n - base), longint'(2 + EXTRA));
        check("case2a_b0", longint'(log_b[base]),     8'h3F);
        check("case2a_b1", longint'(log_b[base + 1]), 8'h3C);
        repeat (2) @(negedge clk);

        // Case 2b: all lanes disabled -> word dropped, word_done 3 cycles after FIFO non-empty.
        ch_mask = 2'b00;
        st0 = log_n; wd0 = wd_n;
        push(32'hFF3C_C0A5);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (word_done) begin lat = i; break; end
        end
        check("drop_word_done_latency", longint'(lat), 3);
        repeat (8) @(negedge clk);
        check("drop_no_tx", longint'(log_n - st0), 0);
        check("drop_one_word_done", longint'(wd_n - wd0), 1);

        // Case 3: UART misses the second tx_start; WAIT_HI must time out and carry on.
        ch_mask = 2'b11;
        base = log_n; wd0 = wd_n;
        ign_lo = ustart_n + 2;
        ign_hi = ustart_n + 2;
        push(32'h7F81_4002);
        wait_wd(wd0 + 1, 200, "case3_hang");
        check("case3_count", longint'(log_n - base), longint'(4 + EXTRA));
        check("case3_b1", longint'(log_b[base + 1]), 8'h02);
        check("case3_b3", longint'(log_b[base + 3]), 8'h81);
        ign_hi = -1;
        repeat (2) @(negedge clk);

        // Case 4: three words queued back to back.
        base = log_n; wd0 = wd_n; rd0 = rd_n;
        push(32'hABCD_1234);
        push(32'h0123_4567);
        push(32'hFFFF_FFFF);
        wait_wd(wd0 + 3, 600, "case4_word_done_timeout");
        check("case4_reads", longint'(rd_n - rd0), 3);
        check("case4_count", longint'(log_n - base), longint'(3 * (4 + EXTRA)));
        check("case4_w0_b2", longint'(log_b[base + 2]), 8'h2B);
        check("case4_w2_b0", longint'(log_b[base + 2 * (4 + EXTRA)]), 8'h3F);
        repeat (2) @(negedge clk);

        // Case 5: reset during the second byte, then a fresh word.
        base = log_n;
        push(32'hFF3C_C0A5);
        wait_log(base + 2, 100, "case5_second_byte_timeout");
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("midword_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        base = log_n; wd0 = wd_n; rd0 = rd_n;
        repeat (3) @(negedge clk);
        check("case5_no_reread", longint'(rd_n - rd0), 0);
        push(32'h1234_2ABC);
        wait_wd(wd0 + 1, 200, "case5_word_done_timeout");
        check("case5_reads", longint'(rd_n - rd0), 1);
        check("case5_count", longint'(log_n - base), longint'(4 + EXTRA));
        check("case5_b0", longint'(log_b[base]),     8'h2A);
        check("case5_b1", longint'(log_b[base + 1]), 8'hBC);
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
